// File: rtl/hb_read_capture_if.sv
// hb_read_capture_if
//   Groups the HyperBus read-data inputs and the captured-word valid/ready
//   handshake of hb_read_capture.
//   rwds_i       : RWDS, already synchronised to the system clock
//   dq_i         : DQ byte, aligned with rwds_i
//   word_o       : captured 32-bit word
//   word_valid_o : word_o holds a word not yet accepted
//   word_ready_i : consumer accepts word_o
//   slave  modport : the capture block
//   master modport : the pad side plus the word consumer
interface hb_read_capture_if;
  logic        rwds_i;
  logic [7:0]  dq_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;

  modport slave (
    input  rwds_i,
    input  dq_i,
    input  word_ready_i,
    output word_o,
    output word_valid_o
  );

  modport master (
    output rwds_i,
    output dq_i,
    output word_ready_i,
    input  word_o,
    input  word_valid_o
  );
endinterface

// File: rtl/hb_read_capture.sv
// hb_read_capture
//   HyperBus read-data capture. After start_i it turns every RWDS transition
//   into a DQ byte, packs four bytes into a 32-bit word and offers each word
//   on a valid/ready handshake. A watchdog aborts the burst when RWDS stops
//   toggling for TIMEOUT_CYCLES consecutive cycles.
//   wb_clk_i        : system clock, rising edge
//   wb_rstn_i       : synchronous reset, active-low
//   start_i         : one-cycle pulse starting a burst (ignored while busy)
//   burst_len_i     : number of words in the burst, sampled with start_i
//   bus             : RWDS/DQ inputs and the word handshake (slave side)
//   busy_o          : burst in progress (CAPTURE or DRAIN)
//   done_o          : one-cycle pulse when a burst completes
//   hb_read_timeout : sticky, RWDS stalled during capture
//   overrun_o       : sticky, a completed word found the output still full
module hb_read_capture #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8,
  parameter int LEN_W          = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  hb_read_capture_if.slave  bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              hb_read_timeout,
  output logic              overrun_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic              rwds_q;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;

  logic              rwds_edge;
  logic              handshake;
  logic [CNT_W-1:0]  wdog_next;

  // Saturating increment: the watchdog must never wrap back to a small value.
  function automatic logic [CNT_W-1:0] wdog_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign rwds_edge = (bus.rwds_i != rwds_q);
  assign handshake = word_valid_q & bus.word_ready_i;
  assign wdog_next = wdog_inc(wdog_q);

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    wdog_d       = wdog_q;
    words_left_d = words_left_q;
    asm_d        = asm_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;

    // An accepted word frees the output register; a load below overrides.
    if (handshake) begin
      word_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (burst_len_i != '0) begin
            words_left_d = burst_len_i;
            byte_idx_d   = 2'd0;
            wdog_d       = '0;
            timeout_d    = 1'b0;
            overrun_d    = 1'b0;
            state_d      = CAPTURE;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      CAPTURE: begin
        if (rwds_edge) begin
          // HyperBus delivers each 16-bit half big-endian, low half first.
          unique case (byte_idx_q)
            2'd0: asm_d[15:8]  = bus.dq_i;
            2'd1: asm_d[7:0]   = bus.dq_i;
            2'd2: asm_d[31:24] = bus.dq_i;
            2'd3: asm_d[23:16] = bus.dq_i;
            default: asm_d = asm_q;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          wdog_d     = '0;
          if (byte_idx_q == 2'd3) begin
            if (!word_valid_q || handshake) begin
              word_d       = {asm_q[31:24], bus.dq_i, asm_q[15:0]};
              word_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            words_left_d = words_left_q - LEN_W'(1);
            if (words_left_q == LEN_W'(1)) begin
              state_d = DRAIN;
            end
          end
        end else begin
          wdog_d = wdog_next;
          // Abort without done_o; any pending word stays offered.
          if (wdog_next == WDOG_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      DRAIN: begin
        if (!word_valid_q || handshake) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q      <= IDLE;
      rwds_q       <= 1'b0;
      byte_idx_q   <= 2'd0;
      wdog_q       <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rwds_q       <= bus.rwds_i;
      byte_idx_q   <= byte_idx_d;
      wdog_q       <= wdog_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  // The assembly register is pure data: every byte is rewritten before use.
  always_ff @(posedge wb_clk_i) begin
    asm_q <= asm_d;
  end

  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;
  assign hb_read_timeout  = timeout_q;
  assign overrun_o        = overrun_q;
  assign bus.word_o       = word_q;
  assign bus.word_valid_o = word_valid_q;

endmodule
